// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller that time-shares one external
// 1-bit full-adder cell to add two WIDTH-bit operands, LSB first.
//
// Optional feature macro: SERIAL_ADD_OVF_EN adds the `ovf` output. This is the
// two's-complement signed overflow, latched together with cout.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   op_a, op_b, cin     operands and carry-in, sampled on accept
//   fa_a, fa_b, fa_c    drive to the shared full-adder cell (0 outside RUN)
//   fa_sum, fa_carry    combinational results from the cell
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   sum, cout           result, held until the next accept
//   busy                high in RUN or DONE
//   ovf                 signed overflow (only with SERIAL_ADD_OVF_EN)
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
`ifdef SERIAL_ADD_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = cin;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Shifting in zeros leaves a_q/b_q at 0 after the last bit,
                // so fa_a/fa_b are quiet outside RUN without extra gating.
                sum_d   = sum_q | (WIDTH'(fa_sum) << cnt_q);
                carry_d = fa_carry;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cout_d  = fa_carry;
                    carry_d = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q here is the carry into the MSB
                    ovf_d   = carry_q ^ fa_carry;
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    assign fa_a      = a_q[0];
    assign fa_b      = b_q[0];
    assign fa_c      = carry_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
